// File: rtl/osd_mixer_pkg.sv
// Shared constants, commit FSM encoding and default palette for the OSD output mixer.
package osd_mixer_pkg;

  localparam logic [1:0] BLEND_OPAQUE  = 2'd0;
  localparam logic [1:0] BLEND_HALF    = 2'd1;
  localparam logic [1:0] BLEND_QUARTER = 2'd2;

  typedef enum logic {CM_IDLE = 1'b0, CM_PENDING = 1'b1} commit_state_e;

  // Entry packed {R,G,B} into the low 3*cb bits; idx0 black, 1 blue, 2 yellow, 3 white.
  function automatic logic [95:0] default_pal_entry(input int unsigned idx, input int unsigned cb);
    logic [95:0] f, r, g, b;
    f = (96'd1 << cb) - 96'd1;
    r = '0;
    g = '0;
    b = '0;
    case (idx)
      1: b = f;
      2: begin r = f; g = f; end
      3: begin r = f; g = f; b = f; end
      default: ;
    endcase
    return (r << (2 * cb)) | (g << cb) | b;
  endfunction

endpackage

// File: rtl/osd_output_mixer_if.sv
// CPU-side palette access bus: shadow writes, commit request and busy status.
interface osd_output_mixer_if #(
  parameter int COLOR_BITS     = 8,
  parameter int OSD_COLOR_BITS = 2
);
  logic                      pal_wr;
  logic [OSD_COLOR_BITS-1:0] pal_addr;
  logic [3*COLOR_BITS-1:0]   pal_data;
  logic                      pal_commit;
  logic                      pal_busy;

  modport master (output pal_wr, pal_addr, pal_data, pal_commit, input  pal_busy);
  modport slave  (input  pal_wr, pal_addr, pal_data, pal_commit, output pal_busy);
endinterface

// File: rtl/osd_blend_channel.sv
// One colour channel of the stage-2 mix. Blend adders exist only with OSD_MIXER_BLEND_EN;
// otherwise every overlay pixel is opaque.
module osd_blend_channel
  import osd_mixer_pkg::*;
#(
  parameter int COLOR_BITS = 8
) (
  input  logic [COLOR_BITS-1:0] vid_i,
  input  logic [COLOR_BITS-1:0] osd_i,
  input  logic                  ovl_i,
  input  logic [1:0]            mode_i,
  output logic [COLOR_BITS-1:0] mix_o
);
`ifdef OSD_MIXER_BLEND_EN
  localparam int W = COLOR_BITS + 2;
  logic [W-1:0] v_w, o_w, half_w, qtr_w;

  assign v_w    = W'(vid_i);
  assign o_w    = W'(osd_i);
  assign half_w = (v_w + o_w + W'(1)) >> 1;
  assign qtr_w  = (W'(3) * v_w + o_w + W'(2)) >> 2;

  always_comb begin
    mix_o = vid_i;
    if (ovl_i) begin
      case (mode_i)
        BLEND_HALF:    mix_o = half_w[COLOR_BITS-1:0];
        BLEND_QUARTER: mix_o = qtr_w[COLOR_BITS-1:0];
        default:       mix_o = osd_i;
      endcase
    end
  end
`else
  logic [1:0] unused_mode;
  assign unused_mode = mode_i;
  assign mix_o = ovl_i ? osd_i : vid_i;
`endif
endmodule

// File: rtl/osd_output_mixer.sv
// OSD overlay/output stage: palette lookup, replace or blend, PIPE_STAGES fixed latency.
// Optional blending via OSD_MIXER_BLEND_EN; palette commits land on VSYNC rise.
module osd_output_mixer
  import osd_mixer_pkg::*;
#(
  parameter int COLOR_BITS     = 8,
  parameter int OSD_COLOR_BITS = 2,
  parameter int PIPE_STAGES    = 2
) (
  input  logic                      PCLK_i,
  input  logic                      reset_n,
  input  logic [COLOR_BITS-1:0]     R_i,
  input  logic [COLOR_BITS-1:0]     G_i,
  input  logic [COLOR_BITS-1:0]     B_i,
  input  logic                      HSYNC_i,
  input  logic                      VSYNC_i,
  input  logic                      DE_i,
  input  logic                      osd_enable_i,
  input  logic [OSD_COLOR_BITS-1:0] osd_color_i,
  input  logic [1:0]                blend_mode_i,
  osd_output_mixer_if.slave         pal,
  output logic [COLOR_BITS-1:0]     R_o,
  output logic [COLOR_BITS-1:0]     G_o,
  output logic [COLOR_BITS-1:0]     B_o,
  output logic                      HSYNC_o,
  output logic                      VSYNC_o,
  output logic                      DE_o
);
  localparam int NPAL = 2 ** OSD_COLOR_BITS;
  typedef logic [2:0][COLOR_BITS-1:0] rgb_t;

  rgb_t [NPAL-1:0] pal_dflt, shadow_q, active_q;

  for (genvar i = 0; i < NPAL; i++) begin : g_dflt
    localparam logic [95:0] D = default_pal_entry(i, COLOR_BITS);
    assign pal_dflt[i] = D[3*COLOR_BITS-1:0];
  end

  // Commit FSM
  commit_state_e state_q, state_d;
  logic          vs_q, vs_rise, copy;

  assign vs_rise      = VSYNC_i & ~vs_q;
  assign pal.pal_busy = (state_q == CM_PENDING);

  always_comb begin
    state_d = state_q;
    copy    = 1'b0;
    case (state_q)
      CM_IDLE:    if (pal.pal_commit) state_d = CM_PENDING;
      CM_PENDING: if (vs_rise) begin
        state_d = CM_IDLE;
        copy    = 1'b1;
      end
      default:    state_d = CM_IDLE;
    endcase
  end

  // Copy reads the pre-write shadow, so a write in the copy cycle only reaches shadow.
  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= CM_IDLE;
      vs_q     <= 1'b0;
      shadow_q <= pal_dflt;
      active_q <= pal_dflt;
    end else begin
      state_q <= state_d;
      vs_q    <= VSYNC_i;
      if (copy) active_q <= shadow_q;
      if (pal.pal_wr) shadow_q[pal.pal_addr] <= pal.pal_data;
    end
  end

  // Pixel pipeline: stage 1 lookup, stage 2 mix, then plain delay
  rgb_t                   vid1_q, osd1_q, mix_d;
  logic                   ovl1_q;
  logic [1:0]             mode1_q;
  rgb_t [PIPE_STAGES:2]   pix_q;
  logic [PIPE_STAGES:1][2:0] tmg_q;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    osd_blend_channel #(.COLOR_BITS(COLOR_BITS)) u_ch (
      .vid_i  (vid1_q[c]),
      .osd_i  (osd1_q[c]),
      .ovl_i  (ovl1_q),
      .mode_i (mode1_q),
      .mix_o  (mix_d[c])
    );
  end

  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      vid1_q  <= '0;
      osd1_q  <= '0;
      ovl1_q  <= 1'b0;
      mode1_q <= BLEND_OPAQUE;
      pix_q   <= '0;
      tmg_q   <= '0;
    end else begin
      vid1_q   <= {R_i, G_i, B_i};
      osd1_q   <= active_q[osd_color_i];
      ovl1_q   <= osd_enable_i & DE_i;
      mode1_q  <= blend_mode_i;
      pix_q[2] <= mix_d;
      for (int k = 3; k <= PIPE_STAGES; k++) pix_q[k] <= pix_q[k-1];
      tmg_q[1] <= {HSYNC_i, VSYNC_i, DE_i};
      for (int k = 2; k <= PIPE_STAGES; k++) tmg_q[k] <= tmg_q[k-1];
    end
  end

  assign {R_o, G_o, B_o}           = pix_q[PIPE_STAGES];
  assign {HSYNC_o, VSYNC_o, DE_o}  = tmg_q[PIPE_STAGES];

endmodule

// File: tb/tb_osd_output_mixer.sv
// Scoreboard bench for osd_output_mixer: directed pixels push expectations, a monitor checks them.
module tb_osd_output_mixer;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] R_i, G_i, B_i, R_o, G_o, B_o;
  logic       HS_i, VS_i, DE_i, en_i, HS_o, VS_o, DE_o;
  logic [1:0] idx_i, mode_i;

  osd_output_mixer_if #(.COLOR_BITS(8), .OSD_COLOR_BITS(2)) pal();

  osd_output_mixer #(.COLOR_BITS(8), .OSD_COLOR_BITS(2), .PIPE_STAGES(2)) dut (
    .PCLK_i(clk), .reset_n(rst_n),
    .R_i(R_i), .G_i(G_i), .B_i(B_i),
    .HSYNC_i(HS_i), .VSYNC_i(VS_i), .DE_i(DE_i),
    .osd_enable_i(en_i), .osd_color_i(idx_i), .blend_mode_i(mode_i),
    .pal(pal.slave),
    .R_o(R_o), .G_o(G_o), .B_o(B_o),
    .HSYNC_o(HS_o), .VSYNC_o(VS_o), .DE_o(DE_o)
  );

  typedef struct {int due; int id; logic [26:0] exp;} sb_t;
  sb_t sb[$];
  int cyc = 0, vectors = 0, miscompares = 0, nvec = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: output for a pixel driven at cycle k is due at cycle k+2
  always @(negedge clk) begin
    sb_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      vectors++;
      if (e.due != cyc) begin
        miscompares++;
        $display("FAIL vec%0d not checked at due cycle %0d (now %0d)", e.id, e.due, cyc);
      end else if ({R_o, G_o, B_o, HS_o, VS_o, DE_o} !== e.exp) begin
        miscompares++;
        $display("FAIL vec%0d rgb/hs/vs/de got %h/%b%b%b want %h/%b%b%b", e.id,
                 {R_o, G_o, B_o}, HS_o, VS_o, DE_o, e.exp[26:3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
  end

  task automatic px(input logic [23:0] rgb, input logic en, input logic [1:0] idx,
                    input logic de, input logic hs, input logic vs, input logic [23:0] exp);
    {R_i, G_i, B_i} = rgb;
    en_i = en; idx_i = idx; DE_i = de; HS_i = hs; VS_i = vs;
    nvec++;
    sb.push_back('{cyc + 2, nvec, {exp, hs, vs, de}});
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic pal_write(input logic [1:0] a, input logic [23:0] d);
    pal.pal_wr = 1'b1; pal.pal_addr = a; pal.pal_data = d;
  endtask

  initial begin
    {R_i, G_i, B_i} = '0; HS_i = 0; VS_i = 0; DE_i = 0; en_i = 0; idx_i = 0; mode_i = 0;
    pal.pal_wr = 0; pal.pal_addr = 0; pal.pal_data = 0; pal.pal_commit = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {8'h0, R_o, G_o, B_o}, 32'h0);
    chk("rst_tmg", {29'h0, HS_o, VS_o, DE_o}, 32'h0);
    chk("rst_busy", {31'h0, pal.pal_busy}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // default palette lookup, latency, sync alignment, blanking
    px(24'h102030, 1, 2'd2, 1, 0, 0, 24'hFFFF00);
    px(24'h102030, 1, 2'd3, 1, 1, 0, 24'hFFFFFF);
    px(24'h102030, 1, 2'd0, 1, 0, 0, 24'h000000);
    px(24'h405060, 0, 2'd3, 1, 0, 0, 24'h405060);
    px(24'h0A0B0C, 1, 2'd2, 0, 1, 0, 24'h0A0B0C);
    px(24'h0A0B0C, 1, 2'd1, 0, 0, 0, 24'h0A0B0C);

    // mid-frame write + commit, lands after VSYNC rise
    pal_write(2'd1, 24'h123456);
    px(24'h000000, 1, 2'd1, 1, 0, 0, 24'h0000FF);
    pal.pal_wr = 0;
    pal.pal_commit = 1;
    px(24'h000000, 1, 2'd1, 1, 0, 0, 24'h0000FF);
    pal.pal_commit = 0;
    chk("busy_after_commit", {31'h0, pal.pal_busy}, 32'h1);
    px(24'h000000, 1, 2'd1, 1, 0, 0, 24'h0000FF);
    px(24'h000000, 1, 2'd1, 1, 0, 0, 24'h0000FF);
    px(24'h000000, 1, 2'd1, 1, 0, 1, 24'h0000FF);
    chk("busy_after_copy", {31'h0, pal.pal_busy}, 32'h0);
    px(24'h000000, 1, 2'd1, 1, 0, 1, 24'h123456);
    px(24'h000000, 1, 2'd1, 1, 0, 0, 24'h123456);

    // commit coincident with vs_rise is deferred; write in the copy cycle stays in shadow
    pal_write(2'd2, 24'hAABBCC);
    px(24'h000000, 1, 2'd2, 1, 0, 0, 24'hFFFF00);
    pal.pal_wr = 0;
    pal.pal_commit = 1;
    px(24'h000000, 1, 2'd2, 1, 0, 1, 24'hFFFF00);
    pal.pal_commit = 0;
    chk("busy_coincident", {31'h0, pal.pal_busy}, 32'h1);
    px(24'h000000, 1, 2'd2, 1, 0, 1, 24'hFFFF00);
    px(24'h000000, 1, 2'd2, 1, 0, 0, 24'hFFFF00);
    pal_write(2'd2, 24'h445566);
    px(24'h000000, 1, 2'd2, 1, 0, 1, 24'hFFFF00);
    pal.pal_wr = 0;
    chk("busy_deferred_copy", {31'h0, pal.pal_busy}, 32'h0);
    px(24'h000000, 1, 2'd2, 1, 0, 1, 24'hAABBCC);
    pal.pal_commit = 1;
    px(24'h000000, 1, 2'd2, 1, 0, 0, 24'hAABBCC);
    pal.pal_commit = 0;
    px(24'h000000, 1, 2'd2, 1, 0, 1, 24'hAABBCC);
    px(24'h000000, 1, 2'd2, 1, 0, 1, 24'h445566);

    // reset while PENDING
    pal_write(2'd3, 24'h010203);
    px(24'h000000, 1, 2'd2, 1, 0, 0, 24'h445566);
    pal.pal_wr = 0;
    pal.pal_commit = 1;
    px(24'h000000, 1, 2'd2, 1, 0, 0, 24'h445566);
    pal.pal_commit = 0;
    chk("busy_before_reset", {31'h0, pal.pal_busy}, 32'h1);
    {R_i, G_i, B_i} = 24'h777777; en_i = 0; DE_i = 1; HS_i = 1; VS_i = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_rgb", {8'h0, R_o, G_o, B_o}, 32'h777777);
    rst_n = 1'b0;
    #1;
    chk("reset_rgb", {8'h0, R_o, G_o, B_o}, 32'h0);
    chk("reset_tmg", {29'h0, HS_o, VS_o, DE_o}, 32'h0);
    chk("reset_busy", {31'h0, pal.pal_busy}, 32'h0);
    {R_i, G_i, B_i} = '0; DE_i = 0; HS_i = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    px(24'h000000, 1, 2'd1, 1, 0, 0, 24'h0000FF);
    px(24'h000000, 1, 2'd3, 1, 0, 0, 24'hFFFFFF);
    px(24'h000000, 1, 2'd3, 1, 0, 1, 24'hFFFFFF);
    px(24'h000000, 1, 2'd3, 1, 0, 1, 24'hFFFFFF);
    chk("busy_after_reset", {31'h0, pal.pal_busy}, 32'h0);

    // blend modes on O=FF0001, V=00FF80
    pal_write(2'd3, 24'hFF0001);
    pal.pal_commit = 1;
    px(24'h000000, 0, 2'd0, 0, 0, 0, 24'h000000);
    pal.pal_wr = 0; pal.pal_commit = 0;
    px(24'h000000, 0, 2'd0, 0, 0, 1, 24'h000000);
    mode_i = 2'd1;
`ifdef OSD_MIXER_BLEND_EN
    px(24'h00FF80, 1, 2'd3, 1, 0, 1, 24'h808041);
    px(24'h00FF80, 0, 2'd3, 1, 0, 1, 24'h00FF80);
    mode_i = 2'd2;
    px(24'h00FF80, 1, 2'd3, 1, 0, 1, 24'h40BF60);
`else
    px(24'h00FF80, 1, 2'd3, 1, 0, 1, 24'hFF0001);
    px(24'h00FF80, 0, 2'd3, 1, 0, 1, 24'h00FF80);
    mode_i = 2'd2;
    px(24'h00FF80, 1, 2'd3, 1, 0, 1, 24'hFF0001);
`endif
    mode_i = 2'd3;
    px(24'h00FF80, 1, 2'd3, 1, 0, 1, 24'hFF0001);
    mode_i = 2'd0;
    px(24'h00FF80, 1, 2'd3, 1, 0, 0, 24'hFF0001);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
